// File: rtl/xadac_mem_sched_if.sv
// Request/response and single-beat AXI bundle for xadac_mem_sched.
// master = the scheduler; slave = the requesters together with the AXI wizard.
interface xadac_mem_sched_if #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned IdWidth   = 4
);
    logic [NumReq-1:0]             req_valid;
    logic [NumReq-1:0]             req_ready;
    logic [NumReq-1:0]             req_we;
    logic [NumReq*AddrWidth-1:0]   req_addr;
    logic [NumReq*DataWidth-1:0]   req_wdata;
    logic [NumReq*DataWidth/8-1:0] req_wstrb;
    logic [NumReq-1:0]             rsp_valid;
    logic [NumReq-1:0]             rsp_ready;
    logic [DataWidth-1:0]          rsp_rdata;
    logic                          rsp_err;

    logic [IdWidth-1:0]            aw_id;
    logic [AddrWidth-1:0]          aw_addr;
    logic                          aw_valid;
    logic                          aw_ready;
    logic [DataWidth-1:0]          w_data;
    logic [DataWidth/8-1:0]        w_strb;
    logic                          w_valid;
    logic                          w_ready;
    logic [IdWidth-1:0]            b_id;
    logic [1:0]                    b_resp;
    logic                          b_valid;
    logic                          b_ready;
    logic [IdWidth-1:0]            ar_id;
    logic [AddrWidth-1:0]          ar_addr;
    logic                          ar_valid;
    logic                          ar_ready;
    logic [IdWidth-1:0]            r_id;
    logic [DataWidth-1:0]          r_data;
    logic [1:0]                    r_resp;
    logic                          r_valid;
    logic                          r_ready;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
        input  r_id, r_data, r_resp, r_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_id, ar_addr, ar_valid, r_ready
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output aw_ready, w_ready, b_id, b_resp, b_valid, ar_ready,
        output r_id, r_data, r_resp, r_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_id, ar_addr, ar_valid, r_ready
    );
endinterface

// File: rtl/xadac_mem_sched.sv
// Round-robin, single-outstanding scheduler of NumReq requesters onto one AXI slave; grant same cycle, AXI valids next.
// Holds every valid until its handshake; XADAC_SCHED_TIMEOUT_EN adds a watchdog that completes a stuck transaction with err.
module xadac_mem_sched #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 128,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    xadac_mem_sched_if.master    bus
);
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned StrbW = DataWidth / 8;

    if (((1 << IdWidth) < NumReq) || (TimeoutCycles == 0)) begin : g_cfg_check
        $error("xadac_mem_sched: IdWidth too small for NumReq or TimeoutCycles is zero");
    end

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        rr_q, rr_d, gnt_q, gnt_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [StrbW-1:0]       wstrb_q, wstrb_d;
    logic                   aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                   ar_valid_q, ar_valid_d, err_q, err_d;
    logic                   srch_any;
    logic [IdxW-1:0]        srch_idx, srch_k;
    logic [IdxW:0]          srch_sum;
    logic                   busy, tmo_hit;

    assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                  (state_q == RD_REQ) || (state_q == RD_RESP);

`ifdef XADAC_SCHED_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Held at zero outside the bus phases, so every new transaction starts from zero.
    always_comb begin
        tmo_d = busy ? tmo_q + 1'b1 : '0;
    end

    assign tmo_hit = busy && (tmo_q == TmoW'(TimeoutCycles - 1));

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // First valid requester at or above the round-robin pointer, wrapping.
    always_comb begin
        srch_any = 1'b0;
        srch_idx = '0;
        srch_k   = '0;
        srch_sum = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            srch_sum = {1'b0, rr_q} + (IdxW+1)'(i);
            if (srch_sum >= (IdxW+1)'(NumReq)) srch_sum = srch_sum - (IdxW+1)'(NumReq);
            srch_k = srch_sum[IdxW-1:0];
            if (!srch_any && bus.req_valid[srch_k]) begin
                srch_any = 1'b1;
                srch_idx = srch_k;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        aw_valid_d    = aw_valid_q;
        w_valid_d     = w_valid_q;
        ar_valid_d    = ar_valid_q;
        bus.req_ready = '0;

        case (state_q)
            IDLE: begin
                if (srch_any && !rst) begin
                    bus.req_ready[srch_idx] = 1'b1;
                    gnt_d   = srch_idx;
                    rr_d    = (srch_idx == IdxW'(NumReq - 1)) ? '0 : srch_idx + 1'b1;
                    addr_d  = bus.req_addr[srch_idx*AddrWidth +: AddrWidth];
                    wdata_d = bus.req_wdata[srch_idx*DataWidth +: DataWidth];
                    wstrb_d = bus.req_wstrb[srch_idx*StrbW +: StrbW];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (bus.req_we[srch_idx]) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WR_REQ;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (tmo_hit) begin
                    aw_valid_d = 1'b0;
                    w_valid_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RSP;
                end else begin
                    if (aw_valid_q && bus.aw_ready) aw_valid_d = 1'b0;
                    if (w_valid_q && bus.w_ready)   w_valid_d  = 1'b0;
                    if (!aw_valid_d && !w_valid_d)  state_d    = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.b_valid) begin
                    err_d   = (bus.b_resp != 2'b00) || (bus.b_id != IdWidth'(gnt_q));
                    state_d = RSP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RSP;
                end
            end
            RD_REQ: begin
                if (tmo_hit) begin
                    ar_valid_d = 1'b0;
                    err_d      = 1'b1;
                    state_d    = RSP;
                end else if (bus.ar_ready) begin
                    ar_valid_d = 1'b0;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.r_valid) begin
                    rdata_d = bus.r_data;
                    err_d   = (bus.r_resp != 2'b00) || (bus.r_id != IdWidth'(gnt_q));
                    state_d = RSP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (state_q == RSP) bus.rsp_valid[gnt_q] = 1'b1;
    end

    assign bus.rsp_rdata = (state_q == RSP) ? rdata_q : '0;
    assign bus.rsp_err   = (state_q == RSP) && err_q;
    assign bus.aw_id     = IdWidth'(gnt_q);
    assign bus.aw_addr   = addr_q;
    assign bus.aw_valid  = aw_valid_q;
    assign bus.w_data    = wdata_q;
    assign bus.w_strb    = wstrb_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.b_ready   = (state_q == WR_RESP);
    assign bus.ar_id     = IdWidth'(gnt_q);
    assign bus.ar_addr   = addr_q;
    assign bus.ar_valid  = ar_valid_q;
    assign bus.r_ready   = (state_q == RD_RESP);
endmodule

// File: tb/tb_xadac_mem_sched.sv
// Bench for xadac_mem_sched: directed requesters and AXI wizard, responses checked against a scoreboard.
// The watchdog case is compiled only when XADAC_SCHED_TIMEOUT_EN is defined.
module tb_xadac_mem_sched;
    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam int IW  = 4;
    localparam int TMO = 16;

    typedef struct {
        int          idx;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   outstanding = 0;
    exp_t sb[$];

    xadac_mem_sched_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

    xadac_mem_sched #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .TimeoutCycles(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for aw_valid(0), ar_valid(1), b_ready(2) or r_ready(3).
    task automatic wait_hi(input int which, input string tag);
        int   n;
        logic s;
        for (n = 0; n < 64; n++) begin
            case (which)
                0:       s = bus.aw_valid;
                1:       s = bus.ar_valid;
                2:       s = bus.b_ready;
                3:       s = bus.r_ready;
                default: s = 1'b0;
            endcase
            if (s) break;
            step();
        end
        chk(tag, DW'(n < 64), DW'(1));
    endtask

    task automatic send_req(input int i, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
        int n;
        bus.req_we[i]                 = we;
        bus.req_addr[i*AW +: AW]      = addr;
        bus.req_wdata[i*DW +: DW]     = wdata;
        bus.req_wstrb[i*DW/8 +: DW/8] = wstrb;
        bus.req_valid[i]              = 1'b1;
        for (n = 0; n < 64; n++) begin
            #1;
            if (bus.req_ready[i]) break;
            @(posedge clk);
        end
        chk("req_accept", DW'(n < 64), DW'(1));
        step();
        bus.req_valid[i] = 1'b0;
    endtask

    // Response monitor: pops the scoreboard on each response handshake.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic [N-1:0]  ev;
        if (rst) begin
            outstanding = 0;
        end else begin
            if (|(bus.req_valid & bus.req_ready)) begin
                chk("single_accept", DW'(outstanding), DW'(0));
                chk("accept_onehot", DW'($countones(bus.req_ready)), DW'(1));
                outstanding = 1;
            end
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", DW'(bus.rsp_valid), DW'(0));
                end else begin
                    e = sb.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("rsp_valid", DW'(bus.rsp_valid), DW'(ev));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_err", DW'(bus.rsp_err), DW'(e.err));
                end
                outstanding = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] wd;
        int            n;
        bus.req_valid = '0;  bus.req_we = '0;    bus.req_addr = '0;
        bus.req_wdata = '0;  bus.req_wstrb = '0; bus.rsp_ready = '1;
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        bus.b_id = '0;       bus.b_resp = '0;    bus.b_valid = 1'b0;
        bus.ar_ready = 1'b0; bus.r_id = '0;      bus.r_data = '0;
        bus.r_resp = '0;     bus.r_valid = 1'b0;

        // Reset state, with requests pending that must not be accepted.
        rst = 1'b1;
        bus.req_valid = '1;
        step();
        step();
        chk("rst_req_ready", DW'(bus.req_ready), DW'(0));
        chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("rst_aw_valid", DW'(bus.aw_valid), DW'(0));
        chk("rst_w_valid", DW'(bus.w_valid), DW'(0));
        chk("rst_ar_valid", DW'(bus.ar_valid), DW'(0));
        chk("rst_b_ready", DW'(bus.b_ready), DW'(0));
        chk("rst_r_ready", DW'(bus.r_ready), DW'(0));
        chk("rst_rsp_rdata", bus.rsp_rdata, '0);
        chk("rst_rsp_err", DW'(bus.rsp_err), DW'(0));
        chk("rst_aw_addr", DW'(bus.aw_addr), DW'(0));
        bus.req_valid = '0;
        rst = 1'b0;
        step();

        // Single store from requester 0, aw and w accepted together.
        sb.push_back('{0, '0, 1'b0});
        send_req(0, 1'b1, 32'h1000, {16{8'hA5}}, 16'hFFFF);
        chk("st_aw_valid", DW'(bus.aw_valid), DW'(1));
        chk("st_aw_addr", DW'(bus.aw_addr), DW'(32'h1000));
        chk("st_aw_id", DW'(bus.aw_id), DW'(0));
        chk("st_w_valid", DW'(bus.w_valid), DW'(1));
        chk("st_w_data", bus.w_data, {16{8'hA5}});
        chk("st_w_strb", DW'(bus.w_strb), DW'(16'hFFFF));
        chk("st_b_ready_early", DW'(bus.b_ready), DW'(0));
        bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
        step();
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        chk("st_aw_drop", DW'(bus.aw_valid), DW'(0));
        chk("st_w_drop", DW'(bus.w_valid), DW'(0));
        chk("st_b_ready", DW'(bus.b_ready), DW'(1));
        bus.b_valid = 1'b1; bus.b_id = 4'd0; bus.b_resp = 2'd0;
        step();
        bus.b_valid = 1'b0;
        chk("st_rsp_valid", DW'(bus.rsp_valid), DW'(2'b01));
        step();

        // Single load from requester 1.
        d = 128'h0123456789abcdef_fedcba9876543210;
        sb.push_back('{1, d, 1'b0});
        send_req(1, 1'b0, 32'h2004, '0, '0);
        chk("ld_ar_valid", DW'(bus.ar_valid), DW'(1));
        chk("ld_ar_addr", DW'(bus.ar_addr), DW'(32'h2004));
        chk("ld_ar_id", DW'(bus.ar_id), DW'(1));
        chk("ld_aw_quiet", DW'(bus.aw_valid), DW'(0));
        chk("ld_r_ready_early", DW'(bus.r_ready), DW'(0));
        bus.ar_ready = 1'b1;
        step();
        bus.ar_ready = 1'b0;
        chk("ld_ar_drop", DW'(bus.ar_valid), DW'(0));
        chk("ld_r_ready", DW'(bus.r_ready), DW'(1));
        bus.r_valid = 1'b1; bus.r_id = 4'd1; bus.r_data = d; bus.r_resp = 2'd0;
        step();
        bus.r_valid = 1'b0; bus.r_data = '0;
        chk("ld_rsp_rdata_held", bus.rsp_rdata, d);
        step();

        // Fairness: both requesters held high, grants must alternate 0,1,0,1.
        bus.req_we = '0;
        bus.req_addr[0*AW +: AW] = 32'h3000;
        bus.req_addr[1*AW +: AW] = 32'h3010;
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            int ex;
            ex = t % 2;
            d = {4{32'hC0DE0000 + 32'(t)}};
            sb.push_back('{ex, d, 1'b0});
            wait_hi(1, "fair_ar_wait");
            chk("fair_id", DW'(bus.ar_id), DW'(ex));
            chk("fair_addr", DW'(bus.ar_addr), DW'(32'h3000 + ex * 16));
            bus.ar_ready = 1'b1;
            step();
            bus.ar_ready = 1'b0;
            if (t == 3) bus.req_valid = '0;
            wait_hi(3, "fair_r_wait");
            bus.r_valid = 1'b1; bus.r_id = IW'(ex); bus.r_data = d;
            step();
            bus.r_valid = 1'b0;
        end
        step();
        step();

        // aw accepted first, w stalled 5 cycles; completes with SLVERR.
        wd = {8{16'hBEEF}};
        sb.push_back('{0, '0, 1'b1});
        send_req(0, 1'b1, 32'h4000, wd, 16'h00F0);
        bus.aw_ready = 1'b1;
        step();
        bus.aw_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("ho_aw_drop", DW'(bus.aw_valid), DW'(0));
            chk("ho_w_hold", DW'(bus.w_valid), DW'(1));
            chk("ho_w_data", bus.w_data, wd);
            chk("ho_w_strb", DW'(bus.w_strb), DW'(16'h00F0));
            chk("ho_b_ready", DW'(bus.b_ready), DW'(0));
            step();
        end
        bus.w_ready = 1'b1;
        step();
        bus.w_ready = 1'b0;
        chk("ho_w_drop", DW'(bus.w_valid), DW'(0));
        chk("ho_b_ready_resp", DW'(bus.b_ready), DW'(1));
        bus.b_valid = 1'b1; bus.b_id = 4'd0; bus.b_resp = 2'd2;
        step();
        bus.b_valid = 1'b0; bus.b_resp = 2'd0;
        step();

        // Load with wrong r_id, response back-pressured for 3 cycles.
        d = 128'h5555aaaa_33334444_deadbeef_00c0ffee;
        sb.push_back('{0, d, 1'b1});
        send_req(0, 1'b0, 32'h5000, '0, '0);
        bus.ar_ready = 1'b1;
        step();
        bus.ar_ready = 1'b0;
        bus.r_valid = 1'b1; bus.r_id = 4'd3; bus.r_data = d; bus.r_resp = 2'd0;
        bus.rsp_ready = '0;
        step();
        bus.r_valid = 1'b0; bus.r_id = '0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_rsp_valid", DW'(bus.rsp_valid), DW'(2'b01));
            chk("bp_rsp_err", DW'(bus.rsp_err), DW'(1));
            step();
        end
        bus.rsp_ready = '1;
        step();
        step();

        // Reset in RD_RESP aborts silently; round-robin pointer returns to 0.
        send_req(0, 1'b0, 32'h7000, '0, '0);
        bus.ar_ready = 1'b1;
        step();
        bus.ar_ready = 1'b0;
        chk("mr_r_ready", DW'(bus.r_ready), DW'(1));
        rst = 1'b1;
        step();
        chk("mr_r_ready_off", DW'(bus.r_ready), DW'(0));
        chk("mr_ar_valid", DW'(bus.ar_valid), DW'(0));
        chk("mr_ar_addr", DW'(bus.ar_addr), DW'(0));
        chk("mr_rsp_valid", DW'(bus.rsp_valid), DW'(0));
        chk("mr_rsp_rdata", bus.rsp_rdata, '0);
        rst = 1'b0;
        step();
        chk("mr_idle_rsp", DW'(bus.rsp_valid), DW'(0));
        bus.req_we = 2'b11;
        bus.req_addr[0*AW +: AW] = 32'h8000;
        bus.req_addr[1*AW +: AW] = 32'h8010;
        bus.req_valid = 2'b11;
        sb.push_back('{0, '0, 1'b0});
        #1;
        chk("mr_rr_reset", DW'(bus.req_ready), DW'(2'b01));
        step();
        bus.req_valid = '0;
        wait_hi(0, "mr_aw_wait");
        chk("mr_aw_addr", DW'(bus.aw_addr), DW'(32'h8000));
        bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
        step();
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        wait_hi(2, "mr_b_wait");
        bus.b_valid = 1'b1; bus.b_id = 4'd0;
        step();
        bus.b_valid = 1'b0;
        step();

`ifdef XADAC_SCHED_TIMEOUT_EN
        // ar never accepted: ar_valid stays high exactly TMO cycles, then error response.
        sb.push_back('{1, '0, 1'b1});
        send_req(1, 1'b0, 32'h6000, '0, '0);
        n = 0;
        while (bus.ar_valid && n < 40) begin
            n++;
            step();
        end
        chk("tmo_len", DW'(n), DW'(TMO));
        chk("tmo_r_ready", DW'(bus.r_ready), DW'(0));
        step();
        step();
`else
        n = 0;
`endif

        step();
        chk("sb_drain", DW'(sb.size()), DW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xadac_mem_sched.md
Name: xadac_mem_sched

Overview:
Single-outstanding round-robin scheduler that shares the vector AXI wizard's slave port between NumReq requesters (e.g. vector load/store unit and DMA helper). Accepts simple valid/ready load/store requests and issues one single-beat wide AXI transaction at a time toward the wizard. Returns one response to the owning requester. Sits between the xadac issue logic and the AXI width-adapting wizard.

Parameters:
NumReq, 2, number of requesters (1..8)
AddrWidth, 32, byte address width
DataWidth, 128, transaction data width (= wizard slave width)
IdWidth, 4, AXI ID width; must satisfy 2**IdWidth >= NumReq
TimeoutCycles, 1024, watchdog limit (only with optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NumReq  per-requester request valid
req_ready  out  NumReq  per-requester request accepted
req_we  in  NumReq  1 = store, 0 = load
req_addr  in  NumReq*AddrWidth  byte address, requester i at slice i
req_wdata  in  NumReq*DataWidth  store data
req_wstrb  in  NumReq*DataWidth/8  store byte strobes
rsp_valid  out  NumReq  response valid, one-hot or zero
rsp_ready  in  NumReq  response accepted
rsp_rdata  out  DataWidth  load data, shared bus
rsp_err  out  1  1 = AXI error, ID mismatch or timeout
aw_id/aw_addr/aw_valid  out  IdWidth/AddrWidth/1  write address to wizard
aw_ready  in  1
w_data/w_strb/w_valid  out  DataWidth/DataWidth/8/1  write data, w_last is tied 1 outside
w_ready  in  1
b_id/b_resp/b_valid  in  IdWidth/2/1  write response
b_ready  out  1
ar_id/ar_addr/ar_valid  out  IdWidth/AddrWidth/1  read address
ar_ready  in  1
r_id/r_data/r_resp/r_valid  in  IdWidth/DataWidth/2/1  read data
r_ready  out  1

Behaviour:
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- Reset: state IDLE, rr pointer 0, all valid/ready outputs 0, rsp_rdata 0, rsp_err 0, aw/ar/w fields 0.
- IDLE: grant the first requester with req_valid set, searching from rr pointer upward with wrap. req_ready[g] is asserted combinationally in IDLE for the granted index only. On that cycle, latch we/addr/wdata/wstrb and set rr = (g+1) mod NumReq. Next state is WR_REQ if we, else RD_REQ. With no valid requests, stay IDLE.
- Grant latency: request accepted in the same cycle; aw_valid/ar_valid are registered and high on the next cycle.
- WR_REQ: aw_valid and w_valid both driven high with aw_id = g. Each is dropped independently after its own handshake; same-cycle handshakes are allowed. Move to WR_RESP once both are done.
- WR_RESP: b_ready = 1. On b_valid, set err = (b_resp != 0) || (b_id != g) and go to RSP.
- RD_REQ: ar_valid = 1 with ar_id = g; on ar handshake go to RD_RESP.
- RD_RESP: r_ready = 1. On r_valid, latch r_data and set err = (r_resp != 0) || (r_id != g); go to RSP.
- RSP: rsp_valid[g] = 1, rsp_rdata = latched data (0 for stores), rsp_err = err. On rsp_ready[g], go to IDLE. The next grant occurs no earlier than the following cycle.
- Held request: a requester whose req_valid stays high while another owns the bus waits. Fairness: a continuously-requesting requester waits at most NumReq-1 transactions.
- Exactly one transaction is outstanding; AXI valids never drop before their handshake.
- Reset asserted mid-transaction aborts to IDLE with no response. The wizard side must also be reset.

Optional Feature:
XADAC_SCHED_TIMEOUT_EN: when defined, a counter of width $clog2(TimeoutCycles+1) clears on entry to WR_REQ/RD_REQ and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP. When it reaches TimeoutCycles, the FSM drops all AXI valids/readies, goes to RSP with err = 1 and data 0, and ignores late AXI responses. When undefined, there is no counter and the FSM waits indefinitely.

Test Plan:
- Single store: req0 addr 0x1000, wdata all 0xA5, wstrb 0xFFFF → aw_addr 0x1000, aw_id 0; b_resp 0 → rsp_valid 0b01, rsp_err 0, rdata 0.
- Single load: req1 addr 0x2004 → ar_addr 0x2004, ar_id 1; r_data 0x0123...EF, r_resp 0 → rsp_valid 0b10, rsp_rdata matches, err 0.
- Fairness: req0 and req1 both held high for 4 transactions → grant order 0,1,0,1. req_ready never asserted twice without an intervening RSP.
- Handshake ordering: w_ready held low 5 cycles after aw handshake → aw_valid drops, w_valid held with stable data, b_ready only in WR_RESP.
- Error: b_resp 2 (SLVERR), and separately r_id 3 with grant 0 → rsp_err 1.
- Timeout (macro on, TimeoutCycles 16): ar_ready tied 0 → ar_valid drops after 16 cycles, rsp_err 1; synchronous rst mid-RD_RESP → all outputs 0 the next cycle.
